srcnn_mac_pipe: RTL
===================

// Module: srcnn_mac_pipe
// PURPOSE
//  Parametrised, pipelined multiply-accumulate unit for SRCNN convolution windows.
//  Mixed-sign multiply, selectable per operand; NUM_STAGE product register stages.
//  Accumulates products over a window marked by first/last tags, with optional
//  saturation. One result per window. Sits between the feature-line buffers and
//  the bias/ReLU stage.
// PARAMETERS
//  DIN0_WIDTH   10  width of din0 (activation)
//  DIN1_WIDTH   10  width of din1 (weight)
//  DIN0_SIGNED  1   1: din0 is two's complement; 0: unsigned
//  DIN1_SIGNED  0   1: din1 is two's complement; 0: unsigned
//  NUM_STAGE    2   total latency in cycles, 1..4 (NUM_STAGE-1 product regs + acc reg)
//  ACC_WIDTH    24  accumulator/dout width; must be >= DIN0_WIDTH+DIN1_WIDTH+1
//  SATURATE     0   1: clamp to signed ACC_WIDTH range; 0: wrap modulo 2^ACC_WIDTH
// PORTS
//  ap_clk    in   1          clock, all state on rising edge
//  ap_rst    in   1          synchronous active-high reset
//  ce        in   1          clock enable; 0 freezes the whole pipeline
//  in_valid  in   1          din0/din1/first/last valid this cycle
//  first     in   1          beat opens a window (acc loads product, not acc+product)
//  last      in   1          beat closes a window (result emitted)
//  din0      in   DIN0_WIDTH operand 0
//  din1      in   DIN1_WIDTH operand 1
//  out_valid out  1          one-cycle pulse: dout holds a completed window result
//  dout      out  ACC_WIDTH  signed window sum; holds until next out_valid
//  sat       out  1          sticky per window: clamp occurred (always 0 if SATURATE=0)
// BEHAVIOUR
//  Reset: out_valid=0, dout=0, sat=0, accumulator=0, all pipeline valid bits=0.
//  Operand extension: each operand extended to width+1 as signed ({msb,din} if signed,
//   {1'b0,din} if unsigned). Product is the signed full-precision result, sign-extended
//   to ACC_WIDTH. No product truncation.
//  Pipeline: valid/first/last travel with the product through NUM_STAGE-1 registers.
//   Accumulate stage updates on cycle NUM_STAGE after an accepted beat (ce=1, in_valid=1).
//   NUM_STAGE=1 means the product is combinational into the accumulate register.
//  ce=0: no register changes anywhere (incl. out_valid, which holds its value).
//   Latency counts ce=1 cycles only.
//  Bubbles (in_valid=0) propagate as invalid stages and leave acc/dout/sat unchanged.
//  Accumulate stage, valid beat:
//   next = first ? prod : acc+prod, computed in ACC_WIDTH+1 bits.
//   SATURATE=1: clamp next to [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1]. On clamp, sat_int
//    is set; first clears sat_int before that beat's own check.
//   SATURATE=0: keep low ACC_WIDTH bits.
//   Clamp applies per beat; a later beat may move the value back inside the range.
//  Emit: a valid beat with last=1 writes dout=next and sat=sat_int (incl. this beat)
//   and drives out_valid=1 for exactly one ce cycle. Otherwise out_valid=0 on ce cycles.
//  first&last on the same beat: single-beat window, dout = product.
//  Beat without first after reset or after last: accumulates onto current acc
//   (0 after reset); no error flag.
//  ap_rst mid-window: partial sum and in-flight beats discarded, no out_valid for them.
//   ap_rst overrides ce.
//  Back-to-back windows (last then first on the next cycle) run at full rate, no bubble.
// TESTING (defaults unless stated)
//  T1 first=last=1, din0=10'h3FF(-1), din1=10'h3FF(1023) -> 2 cycles later out_valid=1,
//     dout=24'hFFFC01 (-1023), sat=0.
//  T2 window of 3 beats: (-512,1023),(511,1023),(1,1) -> single out_valid,
//     dout=-1022 (24'hFFFC02).
//  T3 SATURATE=1, ACC_WIDTH=20: two beats (-512,1023) -> dout=20'h80000 (-524288), sat=1;
//     next window (1,1) -> dout=1, sat=0.
//  T4 repeat T2 with ce=0 for 3 cycles mid-window and a 2-cycle in_valid=0 gap
//     -> same dout; out_valid delayed by exactly the ce-low cycles.
//  T5 ap_rst asserted after beat 2 of T2 (ce=0 also) -> no out_valid, dout=0;
//     then T1 -> dout=-1023.
//  T6 NUM_STAGE=1 and NUM_STAGE=4, back-to-back single-beat windows every cycle
//     -> out_valid every cycle, latency 1 and 4 respectively.

Source files
------------

// File: rtl/srcnn_mac_pipe.sv
// srcnn_mac_pipe: pipelined mixed-sign multiply-accumulate for SRCNN convolution
// windows. Products travel through NUM_STAGE-1 register stages with their
// valid/first/last tags. The accumulate register folds them into a window sum,
// which can optionally saturate. One result is emitted per window.
module srcnn_mac_pipe #(
    parameter int DIN0_WIDTH  = 10,
    parameter int DIN1_WIDTH  = 10,
    parameter int DIN0_SIGNED = 1,
    parameter int DIN1_SIGNED = 0,
    parameter int NUM_STAGE   = 2,
    parameter int ACC_WIDTH   = 24,
    parameter int SATURATE    = 0
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst,
    input  logic                  ce,
    input  logic                  in_valid,
    input  logic                  first,
    input  logic                  last,
    input  logic [DIN0_WIDTH-1:0] din0,
    input  logic [DIN1_WIDTH-1:0] din1,
    output logic                  out_valid,
    output logic [ACC_WIDTH-1:0]  dout,
    output logic                  sat
);

    localparam logic [ACC_WIDTH-1:0] SAT_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic [ACC_WIDTH-1:0] SAT_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    logic [ACC_WIDTH-1:0] op0_ext;
    logic [ACC_WIDTH-1:0] op1_ext;
    logic [ACC_WIDTH-1:0] prod_c;

    // Operands are extended straight to ACC_WIDTH. The full product fits in
    // ACC_WIDTH bits, so a plain low-half multiply gives the exact signed product.
    always_comb begin
        op0_ext = {{(ACC_WIDTH-DIN0_WIDTH){1'b0}}, din0};
        op1_ext = {{(ACC_WIDTH-DIN1_WIDTH){1'b0}}, din1};
        if (DIN0_SIGNED != 0) op0_ext = {{(ACC_WIDTH-DIN0_WIDTH){din0[DIN0_WIDTH-1]}}, din0};
        if (DIN1_SIGNED != 0) op1_ext = {{(ACC_WIDTH-DIN1_WIDTH){din1[DIN1_WIDTH-1]}}, din1};
        prod_c = op0_ext * op1_ext;
    end

    // Tagged product as seen by the accumulate stage
    logic [ACC_WIDTH-1:0] stg_prod;
    logic                 stg_valid;
    logic                 stg_first;
    logic                 stg_last;

    if (NUM_STAGE == 1) begin : g_direct
        assign stg_prod  = prod_c;
        assign stg_valid = in_valid;
        assign stg_first = first;
        assign stg_last  = last;
    end else begin : g_pipe
        localparam int NREG = NUM_STAGE - 1;

        logic [NREG-1:0][ACC_WIDTH-1:0] prod_q, prod_d;
        logic [NREG-1:0]                valid_q, valid_d;
        logic [NREG-1:0]                first_q, first_d;
        logic [NREG-1:0]                last_q, last_d;

        // Shift the product and its tags one stage per enabled cycle
        always_comb begin
            prod_d  = prod_q;
            valid_d = valid_q;
            first_d = first_q;
            last_d  = last_q;
            if (ce) begin
                prod_d[0]  = prod_c;
                valid_d[0] = in_valid;
                first_d[0] = first;
                last_d[0]  = last;
                for (int i = 1; i < NREG; i++) begin
                    prod_d[i]  = prod_q[i-1];
                    valid_d[i] = valid_q[i-1];
                    first_d[i] = first_q[i-1];
                    last_d[i]  = last_q[i-1];
                end
            end
        end

        // Product stage registers; reset flushes all in-flight beats
        always_ff @(posedge ap_clk) begin
            if (ap_rst) begin
                prod_q  <= '0;
                valid_q <= '0;
                first_q <= '0;
                last_q  <= '0;
            end else begin
                prod_q  <= prod_d;
                valid_q <= valid_d;
                first_q <= first_d;
                last_q  <= last_d;
            end
        end

        assign stg_prod  = prod_q[NREG-1];
        assign stg_valid = valid_q[NREG-1];
        assign stg_first = first_q[NREG-1];
        assign stg_last  = last_q[NREG-1];
    end

    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic [ACC_WIDTH-1:0] dout_q, dout_d;
    logic                 sat_int_q, sat_int_d;
    logic                 sat_q, sat_d;
    logic                 out_valid_q, out_valid_d;

    logic [ACC_WIDTH-1:0] base_c;
    logic [ACC_WIDTH:0]   sum_c;
    logic [ACC_WIDTH-1:0] next_c;
    logic                 ovf_c;
    logic                 next_sat_c;

    // Accumulate with one guard bit. A first beat restarts both the sum and
    // the sticky clamp flag. A last beat publishes the result for one cycle.
    always_comb begin
        base_c     = stg_first ? '0 : acc_q;
        sum_c      = {base_c[ACC_WIDTH-1], base_c} + {stg_prod[ACC_WIDTH-1], stg_prod};
        ovf_c      = (SATURATE != 0) && (sum_c[ACC_WIDTH] != sum_c[ACC_WIDTH-1]);
        next_c     = sum_c[ACC_WIDTH-1:0];
        if (ovf_c) next_c = sum_c[ACC_WIDTH] ? SAT_MIN : SAT_MAX;
        next_sat_c = (stg_first ? 1'b0 : sat_int_q) | ovf_c;

        acc_d       = acc_q;
        dout_d      = dout_q;
        sat_int_d   = sat_int_q;
        sat_d       = sat_q;
        out_valid_d = out_valid_q;
        if (ce) begin
            out_valid_d = 1'b0;
            if (stg_valid) begin
                acc_d     = next_c;
                sat_int_d = next_sat_c;
                if (stg_last) begin
                    dout_d      = next_c;
                    sat_d       = next_sat_c;
                    out_valid_d = 1'b1;
                end
            end
        end
    end

    // Accumulator and output registers
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            acc_q       <= '0;
            dout_q      <= '0;
            sat_int_q   <= 1'b0;
            sat_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            dout_q      <= dout_d;
            sat_int_q   <= sat_int_d;
            sat_q       <= sat_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid = out_valid_q;
    assign dout      = dout_q;
    assign sat       = sat_q;

endmodule
